itrace_block_serializer: RTL and testbench

- Sits directly downstream of the multiple-retirement stage and upstream of the trace encoder core.
- Accepts up to N retirement blocks per cycle from a producer that cannot be stalled, and buffers them in a circular queue.
- Emits them one per cycle over a valid/ready handshake.
- On overflow it drops whole groups, counts them, and flags the next emitted block so the encoder forces a resync packet.

---
 rtl/mure_pkg.sv | 29 ++
 rtl/lane_compactor.sv | 26 ++
 rtl/itrace_block_serializer.sv | 154 +++++++++++++++
 tb/tb_itrace_block_serializer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mure_pkg.sv
// Shared trace-pipeline types and constants for the retirement-block path.
package mure_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned IRETIRE_LEN = 6;
  localparam int unsigned ITYPE_LEN   = 3;
  localparam int unsigned CAUSE_LEN   = 5;
  localparam int unsigned PRIV_LEN    = 2;

  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = 3'd1;
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT = 3'd2;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        iaddr;
    logic                   resync;
  } ser_entry_s;

  // Only exceptions and interrupts carry a meaningful cause/tval.
  function automatic logic itype_has_cause(input logic [ITYPE_LEN-1:0] itype);
    return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
  endfunction

endpackage

// File: rtl/lane_compactor.sv
// Packs the indices of valid lanes into a dense list (ascending lane order) and counts them.
module lane_compactor #(
  parameter int unsigned N     = 2,
  parameter int unsigned LaneW = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned KW    = $clog2(N + 1)
) (
  input  logic [N-1:0]            valid_i,
  output logic [N-1:0][LaneW-1:0] lane_idx_o,
  output logic [KW-1:0]           k_o
);

  logic [KW-1:0] cnt;

  always_comb begin
    cnt        = '0;
    lane_idx_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (valid_i[i]) begin
        lane_idx_o[cnt[LaneW-1:0]] = LaneW'(i);
        cnt = cnt + KW'(1);
      end
    end
    k_o = cnt;
  end

endmodule

// File: rtl/itrace_block_serializer.sv
// Buffers up to N retirement blocks per cycle and replays them one per cycle; whole groups
// are dropped on overflow and the next stored block is tagged for encoder resync.
module itrace_block_serializer
  import mure_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [N-1:0]                     valid_i,
  input  logic [N-1:0][IRETIRE_LEN-1:0]    iretire_i,
  input  logic [N-1:0]                     ilastsize_i,
  input  logic [N-1:0][ITYPE_LEN-1:0]      itype_i,
  input  logic [N-1:0][XLEN-1:0]           iaddr_i,
  input  logic [CAUSE_LEN-1:0]             cause_i,
  input  logic [XLEN-1:0]                  tval_i,
  input  logic [PRIV_LEN-1:0]              priv_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [IRETIRE_LEN-1:0]           iretire_o,
  output logic                             ilastsize_o,
  output logic [ITYPE_LEN-1:0]             itype_o,
  output logic [XLEN-1:0]                  iaddr_o,
  output logic [CAUSE_LEN-1:0]             cause_o,
  output logic [XLEN-1:0]                  tval_o,
  output logic [PRIV_LEN-1:0]              priv_o,
  output logic                             resync_o,
  output logic                             overflow_o,
  output logic [DROP_CNT_W-1:0]            drop_cnt_o,
  input  logic                             clear_i
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned LaneW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned KW    = $clog2(N + 1);

  ser_entry_s              mem_q [DEPTH];
  ser_entry_s              mem_d [DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    pending_resync_q, pending_resync_d;
  logic                    overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [N-1:0][LaneW-1:0] lane_idx;
  logic [KW-1:0]           k;
  logic                    push_nz, accept, drop, pop;
  ser_entry_s              head;

  lane_compactor #(
    .N     (N),
    .LaneW (LaneW),
    .KW    (KW)
  ) u_lane_compactor (
    .valid_i    (valid_i),
    .lane_idx_o (lane_idx),
    .k_o        (k)
  );

  // Admission uses the registered count only; a same-cycle pop frees no space.
  assign push_nz = (k != '0);
  assign accept  = push_nz && (CntW'(k) <= (CntW'(DEPTH) - count_q));
  assign drop    = push_nz && !accept;
  assign valid_o = (count_q != '0);
  assign pop     = valid_o && ready_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (accept) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (KW'(j) < k) begin
          mem_d[wr_ptr_q + PtrW'(j)] = '{
            iretire:   iretire_i[lane_idx[j]],
            ilastsize: ilastsize_i[lane_idx[j]],
            itype:     itype_i[lane_idx[j]],
            cause:     itype_has_cause(itype_i[lane_idx[j]]) ? cause_i : '0,
            tval:      itype_has_cause(itype_i[lane_idx[j]]) ? tval_i : '0,
            priv:      priv_i,
            iaddr:     iaddr_i[lane_idx[j]],
            resync:    (j == 0) && pending_resync_q
          };
        end
      end
      wr_ptr_d = wr_ptr_q + PtrW'(k);
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + (accept ? CntW'(k) : '0) - CntW'(pop);

    pending_resync_d = pending_resync_q;
    if (drop) begin
      pending_resync_d = 1'b1;
    end else if (accept) begin
      pending_resync_d = 1'b0;
    end

    // A drop in the same cycle as clear_i wins and restarts the count at one.
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_i) begin
        drop_cnt_d = DROP_CNT_W'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end else if (clear_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q            <= '{default: '0};
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      pending_resync_q <= 1'b0;
      overflow_q       <= 1'b0;
      drop_cnt_q       <= '0;
    end else begin
      mem_q            <= mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      pending_resync_q <= pending_resync_d;
      overflow_q       <= overflow_d;
      drop_cnt_q       <= drop_cnt_d;
    end
  end

  // Head fields read as zero while empty so stale slots never leak out.
  assign head = valid_o ? mem_q[rd_ptr_q] : '0;

  assign iretire_o   = head.iretire;
  assign ilastsize_o = head.ilastsize;
  assign itype_o     = head.itype;
  assign iaddr_o     = head.iaddr;
  assign cause_o     = head.cause;
  assign tval_o      = head.tval;
  assign priv_o      = head.priv;
  assign resync_o    = head.resync;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_itrace_block_serializer.sv
// Directed bench for itrace_block_serializer: a per-cycle vector table plus multi-cycle scenarios.
module tb_itrace_block_serializer;
  import mure_pkg::*;

  logic                          clk_i = 1'b0;
  logic                          rst_ni;
  logic [1:0]                    valid_i;
  logic [1:0][IRETIRE_LEN-1:0]   iretire_i;
  logic [1:0]                    ilastsize_i;
  logic [1:0][ITYPE_LEN-1:0]     itype_i;
  logic [1:0][XLEN-1:0]          iaddr_i;
  logic [CAUSE_LEN-1:0]          cause_i;
  logic [XLEN-1:0]               tval_i;
  logic [PRIV_LEN-1:0]           priv_i;
  logic                          valid_o;
  logic                          ready_i;
  logic [IRETIRE_LEN-1:0]        iretire_o;
  logic                          ilastsize_o;
  logic [ITYPE_LEN-1:0]          itype_o;
  logic [XLEN-1:0]               iaddr_o;
  logic [CAUSE_LEN-1:0]          cause_o;
  logic [XLEN-1:0]               tval_o;
  logic [PRIV_LEN-1:0]           priv_o;
  logic                          resync_o;
  logic                          overflow_o;
  logic [1:0]                    drop_cnt_o;
  logic                          clear_i;

  int n_tests = 0;
  int n_fail  = 0;

  itrace_block_serializer #(
    .N          (2),
    .DEPTH      (8),
    .DROP_CNT_W (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .iretire_i   (iretire_i),
    .ilastsize_i (ilastsize_i),
    .itype_i     (itype_i),
    .iaddr_i     (iaddr_i),
    .cause_i     (cause_i),
    .tval_i      (tval_i),
    .priv_i      (priv_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .iretire_o   (iretire_o),
    .ilastsize_o (ilastsize_o),
    .itype_o     (itype_o),
    .iaddr_o     (iaddr_o),
    .cause_o     (cause_o),
    .tval_o      (tval_o),
    .priv_o      (priv_o),
    .resync_o    (resync_o),
    .overflow_o  (overflow_o),
    .drop_cnt_o  (drop_cnt_o),
    .clear_i     (clear_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  valid;
    logic [2:0]  it0, it1;
    logic [31:0] a0, a1;
    logic [4:0]  cause;
    logic [31:0] tval;
    logic [1:0]  priv;
    logic        ready;
    logic        ev;
    logic [31:0] ea;
    logic [2:0]  eit;
    logic [4:0]  ec;
    logic [31:0] et;
    logic [1:0]  ep;
    logic [5:0]  eir;
    logic        el;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push2(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
    valid_i    = v;
    iaddr_i[0] = a0;
    iaddr_i[1] = a1;
    step();
    valid_i = 2'b00;
  endtask

  initial begin
    int n;
    logic [31:0] exp_seq [7];

    rst_ni       = 1'b0;
    valid_i      = '0;
    iretire_i[0] = 6'd5;
    iretire_i[1] = 6'd9;
    ilastsize_i  = 2'b10;
    itype_i      = '0;
    iaddr_i      = '0;
    cause_i      = '0;
    tval_i       = '0;
    priv_i       = '0;
    ready_i      = 1'b0;
    clear_i      = 1'b0;

    vecs[0] = '{2'b01, 0, 0, 32'h8000_0000, 0, 0, 0, 3, 1,
                1, 32'h8000_0000, 0, 0, 0, 3, 5, 0};
    vecs[1] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{2'b11, 0, 1, 32'h1000, 32'h1004, 2, 32'hDEAD, 1, 0,
                1, 32'h1000, 0, 0, 0, 1, 5, 0};
    vecs[3] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 1,
                1, 32'h1004, 1, 2, 32'hDEAD, 1, 9, 1};
    vecs[4] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{2'b10, 0, 2, 0, 32'h100, 7, 32'h55, 2, 1,
                1, 32'h100, 2, 7, 32'h55, 2, 9, 1};
    vecs[6] = '{2'b01, 3, 0, 32'h300, 0, 9, 32'h77, 1, 1,
                1, 32'h300, 3, 0, 0, 1, 5, 0};
    vecs[7] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0};

    // Reset state
    #12;
    chk("rst_valid", 64'(valid_o), 0);
    chk("rst_iaddr", 64'(iaddr_o), 0);
    chk("rst_resync", 64'(resync_o), 0);
    chk("rst_overflow", 64'(overflow_o), 0);
    chk("rst_drop_cnt", 64'(drop_cnt_o), 0);
    rst_ni = 1'b1;
    #1;

    // Table: one cycle per row, outputs checked just after the edge
    for (int i = 0; i < 8; i++) begin
      valid_i    = vecs[i].valid;
      itype_i[0] = vecs[i].it0;
      itype_i[1] = vecs[i].it1;
      iaddr_i[0] = vecs[i].a0;
      iaddr_i[1] = vecs[i].a1;
      cause_i    = vecs[i].cause;
      tval_i     = vecs[i].tval;
      priv_i     = vecs[i].priv;
      ready_i    = vecs[i].ready;
      step();
      chk($sformatf("v%0d_valid", i), 64'(valid_o), 64'(vecs[i].ev));
      chk($sformatf("v%0d_iaddr", i), 64'(iaddr_o), 64'(vecs[i].ea));
      chk($sformatf("v%0d_itype", i), 64'(itype_o), 64'(vecs[i].eit));
      chk($sformatf("v%0d_cause", i), 64'(cause_o), 64'(vecs[i].ec));
      chk($sformatf("v%0d_tval", i), 64'(tval_o), 64'(vecs[i].et));
      chk($sformatf("v%0d_priv", i), 64'(priv_o), 64'(vecs[i].ep));
      chk($sformatf("v%0d_iretire", i), 64'(iretire_o), 64'(vecs[i].eir));
      chk($sformatf("v%0d_ilast", i), 64'(ilastsize_o), 64'(vecs[i].el));
      chk($sformatf("v%0d_resync", i), 64'(resync_o), 0);
    end
    valid_i = '0;
    itype_i = '0;
    cause_i = '0;
    tval_i  = '0;

    // Push+pop at count 3 leaves count 3: exactly three blocks drain
    ready_i = 1'b0;
    push2(2'b11, 32'h10, 32'h14);
    push2(2'b01, 32'h18, 32'h0);
    ready_i = 1'b1;
    push2(2'b01, 32'h1C, 32'h0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid_o) n++;
      step();
    end
    chk("pushpop_count", 64'(n), 3);

    // Overflow: fill to 8, drop one group, then resync on the next stored block
    ready_i = 1'b0;
    for (int c = 0; c < 4; c++) push2(2'b11, 32'h400 + 32'(8 * c), 32'h404 + 32'(8 * c));
    chk("full_overflow", 64'(overflow_o), 0);
    push2(2'b11, 32'h900, 32'h904);
    chk("drop_overflow", 64'(overflow_o), 1);
    chk("drop_cnt1", 64'(drop_cnt_o), 1);
    chk("drop_head", 64'(iaddr_o), 64'h400);
    ready_i = 1'b1;
    step();
    chk("pop_head", 64'(iaddr_o), 64'h404);
    push2(2'b01, 32'h200, 32'h0);
    exp_seq = '{32'h408, 32'h40C, 32'h410, 32'h414, 32'h418, 32'h41C, 32'h200};
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("drain%0d_iaddr", i), 64'(iaddr_o), 64'(exp_seq[i]));
      chk($sformatf("drain%0d_resync", i), 64'(resync_o), (i == 6) ? 64'd1 : 64'd0);
      step();
    end
    chk("drain_empty", 64'(valid_o), 0);

    // Backpressure: head frozen while ready_i is low
    ready_i    = 1'b0;
    priv_i     = 2'd2;
    itype_i[1] = ITYPE_EXC;
    cause_i    = 5'd4;
    tval_i     = 32'hBEEF;
    for (int c = 0; c < 4; c++) push2(2'b11, 32'h600 + 32'(16 * c), 32'h604 + 32'(16 * c));
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp%0d_valid", i), 64'(valid_o), 1);
      chk($sformatf("bp%0d_iaddr", i), 64'(iaddr_o), 64'h600);
      chk($sformatf("bp%0d_cause", i), 64'(cause_o), 0);
      chk($sformatf("bp%0d_priv", i), 64'(priv_o), 2);
    end

    // Saturation (2-bit counter) and clear behaviour
    for (int i = 0; i < 5; i++) push2(2'b11, 32'hA00, 32'hA04);
    chk("sat_cnt", 64'(drop_cnt_o), 3);
    chk("sat_overflow", 64'(overflow_o), 1);
    clear_i = 1'b1;
    step();
    chk("clr_overflow", 64'(overflow_o), 0);
    chk("clr_cnt", 64'(drop_cnt_o), 0);
    push2(2'b11, 32'hB00, 32'hB04);
    clear_i = 1'b0;
    chk("clrdrop_overflow", 64'(overflow_o), 1);
    chk("clrdrop_cnt", 64'(drop_cnt_o), 1);
    chk("clrdrop_head", 64'(iaddr_o), 64'h600);

    // Asynchronous reset mid-burst discards queue and pending resync
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_o), 0);
    chk("arst_overflow", 64'(overflow_o), 0);
    chk("arst_cnt", 64'(drop_cnt_o), 0);
    #1 rst_ni = 1'b1;
    itype_i = '0;
    push2(2'b01, 32'h700, 32'h0);
    chk("post_rst_valid", 64'(valid_o), 1);
    chk("post_rst_iaddr", 64'(iaddr_o), 64'h700);
    chk("post_rst_resync", 64'(resync_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
